// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target with fixed 7-bit address and byte-wide host interface
module i2c_target #(
   parameter logic [6:0] ADDR = 7'h3C
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy
);
   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK, ST_IGNORE
   } state_t;

   state_t     state;
   logic       scl_s1, scl_s2, scl_h;
   logic       sda_s1, sda_s2, sda_h;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       rw;
   logic       ack_ok;
   logic       scl_rise, scl_fall, start_ev, stop_ev;
   logic [7:0] byte_in;

   assign scl_rise = scl_s2 & ~scl_h;
   assign scl_fall = ~scl_s2 & scl_h;
   assign start_ev = scl_s2 & scl_h & sda_h & ~sda_s2;
   assign stop_ev  = scl_s2 & scl_h & ~sda_h & sda_s2;
   assign byte_in  = {shreg[6:0], sda_s2};

   // Synchronize both lines and keep one history stage; idle-high reset avoids a false START
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         {scl_s1, scl_s2, scl_h} <= 3'b111;
         {sda_s1, sda_s2, sda_h} <= 3'b111;
      end else begin
         {scl_s1, scl_s2, scl_h} <= {scl_i, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_h} <= {sda_i, sda_s1, sda_s2};
      end

   // Protocol FSM: START/STOP win over bit handling; sda_oe only moves on SCL fall
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state    <= ST_IDLE;
         bit_cnt  <= 3'd0;
         shreg    <= 8'h00;
         rw       <= 1'b0;
         ack_ok   <= 1'b0;
         sda_oe   <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         if (start_ev) begin
            state   <= ST_ADDR;
            bit_cnt <= 3'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            ack_ok  <= 1'b0;
         end else if (stop_ev) begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               ST_ADDR, ST_WR:
                  if (scl_rise) begin
                     shreg   <= byte_in;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (state == ST_WR) begin
                           rx_data  <= byte_in;
                           rx_valid <= 1'b1;
                           state    <= ST_WR_ACK;
                        end else if (byte_in[7:1] == ADDR) begin
                           state  <= ST_ADDR_ACK;
                           busy   <= 1'b1;
                           rw     <= byte_in[0];
                           tx_req <= byte_in[0];
                        end else begin
                           state <= ST_IGNORE;
                        end
                     end
                  end
               // First fall pulls SDA for the ACK slot, second fall ends it
               ST_ADDR_ACK, ST_WR_ACK:
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else if (state == ST_ADDR_ACK && rw) begin
                        shreg  <= tx_data;
                        sda_oe <= ~tx_data[7];
                        state  <= ST_RD;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= ST_WR;
                     end
                  end
               ST_RD:
                  if (scl_fall) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shreg   <= {shreg[6:0], 1'b0};
                     sda_oe  <= (bit_cnt == 3'd7) ? 1'b0 : ~shreg[6];
                     if (bit_cnt == 3'd7) begin
                        state  <= ST_RD_ACK;
                        ack_ok <= 1'b0;
                     end
                  end
               ST_RD_ACK:
                  if (scl_rise) begin
                     if (sda_s2) begin
                        state  <= ST_IGNORE;
                        busy   <= 1'b0;
                        sda_oe <= 1'b0;
                     end else begin
                        ack_ok <= 1'b1;
                        tx_req <= 1'b1;
                     end
                  end else if (scl_fall && ack_ok) begin
                     shreg   <= tx_data;
                     sda_oe  <= ~tx_data[7];
                     bit_cnt <= 3'd0;
                     ack_ok  <= 1'b0;
                     state   <= ST_RD;
                  end
               default: ;
            endcase
         end
      end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-level I2C master and host model driving i2c_target, with scoreboarded checks
module tb_i2c_target;
   logic       clk = 1'b0;
   logic       rst;
   logic       scl;
   logic       sda_m;
   logic [7:0] tx_data;
   logic       sda_oe, rx_valid, tx_req, busy;
   logic [7:0] rx_data;
   logic       sda_bus;

   int errs = 0;
   int checks = 0;

   logic [7:0] rx_log[$];
   logic [7:0] tx_q[$];
   int         txr_cnt;
   int         rxv_long;
   logic       rxv_d = 1'b0;
   logic       oe_seen;
   logic       busy_seen;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_target dut (
      .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
   );

   always #5 clk = ~clk;

   // Host side: log received bytes, answer tx_req with the next queued byte, watch pulse widths
   always @(negedge clk) begin
      if (rx_valid) rx_log.push_back(rx_data);
      if (rx_valid && rxv_d) rxv_long++;
      rxv_d = rx_valid;
      if (tx_req) begin
         txr_cnt++;
         if (tx_q.size() != 0) tx_data = tx_q.pop_front();
         else tx_data = 8'hFF;
      end
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_logs();
      rx_log.delete();
      tx_q.delete();
      txr_cnt   = 0;
      rxv_long  = 0;
      oe_seen   = 1'b0;
      busy_seen = 1'b0;
   endtask

   task automatic i2c_start();
      tick(6); sda_m = 1'b0; tick(12); scl = 1'b0;
   endtask

   task automatic i2c_rstart();
      tick(2); sda_m = 1'b1; tick(10); scl = 1'b1; tick(12); sda_m = 1'b0; tick(12); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(2); sda_m = 1'b0; tick(10); scl = 1'b1; tick(12); sda_m = 1'b1; tick(12);
   endtask

   task automatic wr_bit(input logic b);
      tick(2); sda_m = b; tick(10); scl = 1'b1; tick(12); scl = 1'b0;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) wr_bit(b[i]);
      tick(2); sda_m = 1'b1; tick(10); scl = 1'b1; tick(6); ack = sda_bus; tick(6); scl = 1'b0;
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         tick(2); sda_m = 1'b1; tick(10); scl = 1'b1; tick(6); b[i] = sda_bus; tick(6); scl = 1'b0;
      end
      tick(2); sda_m = nack; tick(10); scl = 1'b1; tick(12); scl = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
      clear_logs();
      tick(5);
      checks++;
      if ({sda_oe, rx_valid, tx_req, busy, rx_data} !== 12'h000) begin
         errs++;
         $display("FAIL reset_outputs: got oe=%b rxv=%b txr=%b busy=%b rx=%h, want all 0", sda_oe, rx_valid, tx_req, busy, rx_data);
      end
      rst = 1'b1;
      tick(10);
      checks++;
      if (busy_seen !== 1'b0 || oe_seen !== 1'b0) begin
         errs++;
         $display("FAIL reset_idle: busy_seen=%b oe_seen=%b, want 0 0", busy_seen, oe_seen);
      end
   endtask

   task automatic test_write();
      logic [7:0] exp[$];
      logic ack;
      int n;
      clear_logs();
      exp = '{8'hA5, 8'h5A};
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
      i2c_start();
      wr_byte({7'h3C, 1'b0}, ack);
      checks++;
      if (ack !== 1'b0) begin errs++; $display("FAIL write_addr_ack: got %b want 0", ack); end
      checks++;
      if (busy !== 1'b1) begin errs++; $display("FAIL write_busy: got %b want 1", busy); end
      foreach (exp[i]) begin
         wr_byte(exp[i], ack);
         checks++;
         if (ack !== 1'b0) begin errs++; $display("FAIL write_data_ack[%0d]: got %b want 0", i, ack); end
      end
      i2c_stop();
      checks++;
      if (busy !== 1'b0) begin errs++; $display("FAIL write_busy_stop: got %b want 0", busy); end
      checks++;
      if (rx_log.size() !== exp.size()) begin
         errs++; $display("FAIL write_rx_count: got %0d want %0d", rx_log.size(), exp.size());
      end
      foreach (exp[i]) if (i < rx_log.size()) begin
         checks++;
         if (rx_log[i] !== exp[i]) begin errs++; $display("FAIL write_rx_data[%0d]: got %h want %h", i, rx_log[i], exp[i]); end
      end
      checks++;
      if (rxv_long !== 0) begin errs++; $display("FAIL write_rxv_width: got %0d long pulses want 0", rxv_long); end
   endtask

   task automatic test_wrong_addr();
      logic [6:0] a;
      logic ack;
      clear_logs();
      a = 7'h3D;
      if ($urandom_range(0, 1) == 1) begin
         do a = 7'($urandom); while (a == 7'h3C);
      end
      i2c_start();
      wr_byte({a, 1'b0}, ack);
      checks++;
      if (ack !== 1'b1) begin errs++; $display("FAIL wrong_addr_ack: addr %h got %b want 1", a, ack); end
      wr_byte(8'($urandom), ack);
      i2c_stop();
      checks++;
      if (oe_seen !== 1'b0 || rx_log.size() !== 0 || busy_seen !== 1'b0) begin
         errs++;
         $display("FAIL wrong_addr_quiet: oe_seen=%b rx=%0d busy_seen=%b, want 0 0 0", oe_seen, rx_log.size(), busy_seen);
      end
   endtask

   task automatic do_read(input string name, input logic [7:0] bytes[$]);
      logic ack;
      logic [7:0] got;
      clear_logs();
      tx_q = bytes;
      i2c_start();
      wr_byte({7'h3C, 1'b1}, ack);
      checks++;
      if (ack !== 1'b0) begin errs++; $display("FAIL %s_addr_ack: got %b want 0", name, ack); end
      foreach (bytes[i]) begin
         rd_byte(i == bytes.size() - 1, got);
         checks++;
         if (got !== bytes[i]) begin errs++; $display("FAIL %s_data[%0d]: got %h want %h", name, i, got, bytes[i]); end
      end
      tick(5);
      checks++;
      if (sda_oe !== 1'b0 || busy !== 1'b0) begin
         errs++; $display("FAIL %s_nack_release: oe=%b busy=%b want 0 0", name, sda_oe, busy);
      end
      i2c_stop();
      checks++;
      if (txr_cnt !== bytes.size()) begin
         errs++; $display("FAIL %s_tx_req_count: got %0d want %0d", name, txr_cnt, bytes.size());
      end
   endtask

   task automatic test_read();
      logic [7:0] q[$];
      do_read("read", '{8'h81, 8'h3C});
      q.delete();
      for (int i = 0; i < $urandom_range(1, 3); i++) q.push_back(8'($urandom));
      do_read("read_rand", q);
   endtask

   task automatic test_repeated_start();
      logic ack;
      logic [7:0] t, got;
      clear_logs();
      t = 8'($urandom);
      tx_q.push_back(t);
      i2c_start();
      wr_byte({7'h3C, 1'b0}, ack);
      wr_byte(8'h11, ack);
      i2c_rstart();
      wr_byte({7'h3C, 1'b1}, ack);
      checks++;
      if (ack !== 1'b0 || busy !== 1'b1) begin
         errs++; $display("FAIL rstart_addr: ack=%b busy=%b want 0 1", ack, busy);
      end
      checks++;
      if (rx_data !== 8'h11 || rx_log.size() !== 1) begin
         errs++; $display("FAIL rstart_rx: rx=%h count=%0d want 11 1", rx_data, rx_log.size());
      end
      rd_byte(1'b1, got);
      checks++;
      if (got !== t) begin errs++; $display("FAIL rstart_read: got %h want %h", got, t); end
      i2c_stop();
   endtask

   task automatic test_reset_mid();
      logic ack;
      logic [7:0] d;
      clear_logs();
      d = 8'($urandom);
      i2c_start();
      wr_byte({7'h3C, 1'b0}, ack);
      for (int i = 7; i >= 4; i--) wr_bit(d[i]);
      tick(1);
      rst = 1'b0;
      #1;
      checks++;
      if (sda_oe !== 1'b0 || busy !== 1'b0 || rx_data !== 8'h00) begin
         errs++; $display("FAIL reset_mid_outputs: oe=%b busy=%b rx=%h want 0 0 00", sda_oe, busy, rx_data);
      end
      tick(3);
      rst = 1'b1;
      oe_seen = 1'b0;
      for (int i = 3; i >= 0; i--) wr_bit(d[i]);
      wr_bit(1'b1);
      i2c_stop();
      checks++;
      if (rx_log.size() !== 0 || oe_seen !== 1'b0) begin
         errs++; $display("FAIL reset_mid_quiet: rx=%0d oe_seen=%b want 0 0", rx_log.size(), oe_seen);
      end
      d = 8'($urandom);
      i2c_start();
      wr_byte({7'h3C, 1'b0}, ack);
      checks++;
      if (ack !== 1'b0) begin errs++; $display("FAIL reset_mid_next_ack: got %b want 0", ack); end
      wr_byte(d, ack);
      i2c_stop();
      checks++;
      if (rx_log.size() !== 1 || rx_data !== d) begin
         errs++; $display("FAIL reset_mid_next_rx: count=%0d rx=%h want 1 %h", rx_log.size(), rx_data, d);
      end
   endtask

   task automatic test_stop_partial();
      logic ack;
      logic [7:0] d;
      clear_logs();
      d = 8'($urandom);
      i2c_start();
      wr_byte({7'h3C, 1'b0}, ack);
      for (int i = 7; i >= 3; i--) wr_bit(d[i]);
      i2c_stop();
      checks++;
      if (rx_log.size() !== 0 || busy !== 1'b0 || sda_oe !== 1'b0) begin
         errs++; $display("FAIL stop_partial: rx=%0d busy=%b oe=%b want 0 0 0", rx_log.size(), busy, sda_oe);
      end
      oe_seen = 1'b0;
      for (int i = 0; i < 9; i++) wr_bit(1'b1);
      i2c_stop();
      checks++;
      if (oe_seen !== 1'b0 || rx_log.size() !== 0) begin
         errs++; $display("FAIL stop_partial_idle: oe_seen=%b rx=%0d want 0 0", oe_seen, rx_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_wrong_addr();
      test_read();
      test_repeated_start();
      test_reset_mid();
      test_stop_partial();
      test_write();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder for the system's I2C bus; it is the far end of the on-chip I2C master. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address, ACKs, and moves bytes to and from a simple byte-wide host interface. It is used as a bus-functional peer in system simulation and as an FPGA-side target. It does not stretch SCL.

## Interface
- ADDR, 7'h3C, 7-bit target address.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- scl_i  in  1  SCL pin level (input only).
- sda_i  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain, external pull-up).
- rx_data  out  8  last byte written by master.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- tx_data  in  8  byte to return on read.
- tx_req  out  1  one-cycle pulse; host must present next tx_data before the next SCL falling edge.
- busy  out  1  1 from START addressed to us until STOP/START/NACK-end.

## Operation
- Input path: scl_i/sda_i through 2-FF synchronizers, plus one history FF per line; synchronizer and history FFs reset to 1 (idle bus) so reset never creates a false START.
- Events (synchronized domain): SCL rise, SCL fall; START = SDA fall while SCL high; STOP = SDA rise while SCL high. START/STOP take priority over data sampling in the same cycle.
- Data sampled on SCL rise; sda_oe changes only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- IDLE -> ADDR on START. Any state -> ADDR on START (repeated start); any state -> IDLE on STOP, sda_oe cleared same cycle.
- ADDR: shift 8 bits MSB first (bit counter 0..7). After 8th rise: match = byte[7:1]==ADDR. No match -> IGNORE (sda_oe stays 0). Match -> ADDR_ACK, busy=1, latch R/W; if R/W=1 pulse tx_req that cycle.
- ADDR_ACK: at next SCL fall assert sda_oe; at following SCL fall: write -> release, go WR; read -> load shift reg from tx_data, drive bit7 (sda_oe = ~bit), go RD.
- WR: shift 8 bits on rises; on 8th rise update rx_data, pulse rx_valid, go WR_ACK. WR_ACK: sda_oe=1 at next fall, release at following fall, back to WR. Every write byte is ACKed.
- RD: drive bits 6..0 on successive falls; after 8th bit's fall release SDA, go RD_ACK. RD_ACK: sample master ACK on rise: 0 -> pulse tx_req, at next fall load tx_data, drive bit7, go RD; 1 (NACK) -> release, go IGNORE, busy=0.
- IGNORE: sda_oe=0; wait for START or STOP.
- Bit counter 3 bits, wraps 7->0 at each byte boundary; cleared on START.

## Timing
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, state IDLE.
- Pin-to-event latency: 3 clk (2 sync + edge compare). sda_oe update: 1 clk after SCL-fall event (registered output), i.e. 4 clk after pin fall.
- Requirement: SCL high and low phases each >= 8 clk (50 MHz clk supports 400 kHz).
- rx_valid asserted exactly 1 clk, 3 clk after 8th data SCL rise at pin.
- tx_req to tx_data sample: at least half an SCL period (one SCL low/high phase).
- Reset asserted mid-transfer: immediate release of SDA; after deassert block waits in IDLE for next START, ignoring the remainder of the current transfer.
- STOP mid-byte: partial byte discarded, no rx_valid.

## Test plan
- Write 0x78 (addr 0x3C, W), 0xA5, 0x5A, STOP -> ACK on all 3 slots; rx_valid pulses twice with rx_data 0xA5 then 0x5A; busy falls at STOP.
- Address 0x7A (0x3D, W) + 1 byte -> sda_oe never 1; no rx_valid; busy stays 0.
- Read 0x79, tx_data=0x81 then 0x3C, master ACK then NACK -> SDA bits 10000001, 00111100; tx_req pulses twice; SDA released after NACK.
- Write 0x78, 0x11, repeated START, 0x79 read -> rx_data=0x11, second address ACKed, read phase entered with no STOP.
- Reset pulse during bit 4 of a write byte -> sda_oe=0, rx_valid never pulses, next full transaction ACKed normally.
- STOP after 5 bits of data byte -> no rx_valid, state IDLE, busy=0.
